// File: rtl/hsi_mse_pkg.sv
// Shared constants for the MSE datapath buffers.
package hsi_mse_pkg;
  localparam int HSI_FIFO_DEPTH_DEFAULT = 16;
  localparam int HSI_FIFO_AF_MARGIN     = 2;
  localparam int HSI_FIFO_AE_DEFAULT    = 2;
endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/hsi_fifo_level.sv
// Synchronous FIFO with fill level, almost-full/empty thresholds and sticky overflow/underflow.
// Define HSI_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module hsi_fifo_level
  import hsi_mse_pkg::*;
#(
  parameter int DATA_WIDTH             = 16,
  parameter int FIFO_DEPTH             = HSI_FIFO_DEPTH_DEFAULT,
  parameter int ALMOST_FULL_THRESHOLD  = FIFO_DEPTH - HSI_FIFO_AF_MARGIN,
  parameter int ALMOST_EMPTY_THRESHOLD = HSI_FIFO_AE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          full,
  output logic                          almost_full,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int LEVEL_WIDTH = ADDR_WIDTH + 1;
  localparam logic [LEVEL_WIDTH-1:0] LVL_FULL = LEVEL_WIDTH'(FIFO_DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] LVL_AF   = LEVEL_WIDTH'(ALMOST_FULL_THRESHOLD);
  localparam logic [LEVEL_WIDTH-1:0] LVL_AE   = LEVEL_WIDTH'(ALMOST_EMPTY_THRESHOLD);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hsi_fifo_level: FIFO_DEPTH must be a power of two >= 4");
  end
  if (!(ALMOST_EMPTY_THRESHOLD < ALMOST_FULL_THRESHOLD &&
        ALMOST_FULL_THRESHOLD <= FIFO_DEPTH)) begin : g_bad_thr
    $error("hsi_fifo_level: need AE < AF <= FIFO_DEPTH");
  end

  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   overflow_q, overflow_d, underflow_q, underflow_d;
  logic                   wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  assign full         = (level_q == LVL_FULL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_ok       = rd_en & ~empty;
    // A read in the same cycle frees the slot, so a write on full still lands.
    wr_ok       = wr_en & (~full | rd_en);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      level_d     = level_q + LEVEL_WIDTH'(wr_ok) - LEVEL_WIDTH'(rd_ok);
      overflow_d  = overflow_q | (wr_en & ~wr_ok);
      underflow_d = underflow_q | (rd_en & ~rd_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok & ~clear),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

`ifdef HSI_FIFO_FWFT_EN
  assign data_out = empty ? '0 : ram_rdata;
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (clear)      data_out_d = '0;
    else if (rd_ok) data_out_d = ram_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_out_q <= '0;
    else        data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif
endmodule

// File: tb/tb_hsi_fifo_level.sv
// Directed bench for hsi_fifo_level (DW=8, depth 16, AF=14, AE=2); honours HSI_FIFO_FWFT_EN.
module tb_hsi_fifo_level;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       full, almost_full, empty, almost_empty, overflow, underflow;
  logic [4:0] level;

  int n_chk = 0;
  int n_pass = 0;

  hsi_fifo_level #(
    .DATA_WIDTH             (8),
    .FIFO_DEPTH             (16),
    .ALMOST_FULL_THRESHOLD  (14),
    .ALMOST_EMPTY_THRESHOLD (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Apply one cycle of inputs, sample 1ns after the rising edge.
  task automatic step(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
    wr_en = wr; data_in = din; rd_en = rd; clear = clr;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  // Pop one word and check it; FWFT shows the head before the edge, standard mode after.
  task automatic pop_chk(input logic wr, input logic [7:0] din, input logic [7:0] exp, input string tag);
`ifdef HSI_FIFO_FWFT_EN
    chk(tag, data_out, exp);
    step(wr, din, 1'b1, 1'b0);
`else
    step(wr, din, 1'b1, 1'b0);
    chk(tag, data_out, exp);
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".level"}, level, 0);
    chk({tag, ".empty"}, empty, 1);
    chk({tag, ".ae"}, almost_empty, 1);
    chk({tag, ".full"}, full, 0);
    chk({tag, ".af"}, almost_full, 0);
    chk({tag, ".ovf"}, overflow, 0);
    chk({tag, ".unf"}, underflow, 0);
    chk({tag, ".dout"}, data_out, 0);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("rst");

    // 1: five writes, one read, then clear
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("t1.level5", level, 5);
    pop_chk(1'b0, 8'h00, 8'hA0, "t1.pop");
    chk("t1.level4", level, 4);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_idle("t1.clr");

    // 2: fill 0x00..0x0F, watch threshold crossings
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk($sformatf("t2.level%0d", i + 1), level, i + 1);
      chk($sformatf("t2.ae%0d", i + 1), almost_empty, (i + 1 <= 2) ? 1 : 0);
      chk($sformatf("t2.af%0d", i + 1), almost_full, (i + 1 >= 14) ? 1 : 0);
      chk($sformatf("t2.full%0d", i + 1), full, (i + 1 == 16) ? 1 : 0);
    end

    // 3: write on full is dropped; drain returns 0x00..0x0F only
    step(1'b1, 8'h20, 1'b0, 1'b0);
    chk("t3.ovf", overflow, 1);
    chk("t3.level", level, 16);
    chk("t3.unf", underflow, 0);
    for (int i = 0; i < 16; i++) begin
      pop_chk(1'b0, 8'h00, 8'(i), $sformatf("t3.rd%0d", i));
      chk($sformatf("t3.lvl%0d", i), level, 15 - i);
    end
    chk("t3.empty", empty, 1);

    // 4: read on empty
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4.unf", underflow, 1);
    chk("t4.level", level, 0);
    chk("t4.ovf_sticky", overflow, 1);
`ifdef HSI_FIFO_FWFT_EN
    chk("t4.dout", data_out, 8'h00);
`else
    chk("t4.dout", data_out, 8'h0F);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_idle("t4.clr");

    // 5: full with simultaneous read+write keeps level at 16
    for (int i = 0; i < 16; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pop_chk(1'b1, 8'h30 + 8'(i), 8'h50 + 8'(i), $sformatf("t5.rw%0d", i));
      chk($sformatf("t5.level%0d", i), level, 16);
      chk($sformatf("t5.full%0d", i), full, 1);
    end
    chk("t5.ovf", overflow, 0);
    for (int i = 4; i < 16; i++) pop_chk(1'b0, 8'h00, 8'h50 + 8'(i), $sformatf("t5.d%0d", i));
    for (int i = 0; i < 4; i++) pop_chk(1'b0, 8'h00, 8'h30 + 8'(i), $sformatf("t5.n%0d", i));
    chk("t5.empty", empty, 1);
    chk("t5.unf", underflow, 0);

    // 6: empty with simultaneous read+write: write lands, read rejected
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h40, 1'b1, 1'b0);
    chk("t6.level", level, 1);
    chk("t6.unf", underflow, 1);
    chk("t6.dout_hold", data_out, 8'h00 | (dut_fwft() ? 8'h40 : 8'h00));
    pop_chk(1'b0, 8'h00, 8'h40, "t6.pop");
    chk("t6.empty", empty, 1);

    // Asynchronous reset mid-cycle discards everything at once
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0);
    chk("rst2.pre", level, 2);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rst2");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("rst2.rel");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic bit dut_fwft();
`ifdef HSI_FIFO_FWFT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction
endmodule
